// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a 16x oversampled baud tick.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [7:0]  data_out,
  input  logic [10:0] dvsr,
  output logic        tx,
  output logic        tx_done,
  output logic        tx_done_tick,
  output logic        tx_busy
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [10:0]     bcnt_q, bcnt_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [7:0]      b_q, b_d;
  logic            tx_q, tx_d;
  logic            accept;
  logic            s_tick;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign s_tick = (bcnt_q == dvsr);

  // Next-state, datapath updates and registered line level
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    accept       = 1'b0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          accept  = 1'b1;
          state_d = START;
          b_d     = data_out;
          s_d     = '0;
          n_d     = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_out;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            tx_done_tick = 1'b1;
            s_d          = '0;
            state_d      = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Restarting the baud counter on acceptance aligns bit timing to the start bit
    if (accept || s_tick) begin
      bcnt_d = '0;
    end else begin
      bcnt_d = bcnt_q + 11'd1;
    end

    // Line level follows the next state so tx changes on the same edge as the state
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_done = (state_q == IDLE);
  assign tx_busy = ~tx_done;

endmodule
